// File: rtl/xif_coproc_mux.sv
// Fans one core-side X-interface out to NUM_COPROC coprocessors. It records which
// coprocessor owns each instruction id and merges their results round-robin.
module xif_coproc_mux #(
  parameter int NUM_COPROC = 2,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             x_issue_valid_i,
  output logic                             x_issue_ready_o,
  input  logic [ID_WIDTH-1:0]              x_issue_id_i,
  input  logic [31:0]                      x_issue_instr_i,
  output logic                             x_issue_accept_o,
  output logic [NUM_COPROC-1:0]            c_issue_valid_o,
  input  logic [NUM_COPROC-1:0]            c_issue_ready_i,
  input  logic [NUM_COPROC-1:0]            c_issue_accept_i,
  output logic [ID_WIDTH-1:0]              c_issue_id_o,
  output logic [31:0]                      c_issue_instr_o,
  input  logic                             x_commit_valid_i,
  input  logic [ID_WIDTH-1:0]              x_commit_id_i,
  input  logic                             x_commit_kill_i,
  output logic [NUM_COPROC-1:0]            c_commit_valid_o,
  output logic [ID_WIDTH-1:0]              c_commit_id_o,
  output logic                             c_commit_kill_o,
  input  logic [NUM_COPROC-1:0]            c_result_valid_i,
  output logic [NUM_COPROC-1:0]            c_result_ready_o,
  input  logic [NUM_COPROC*ID_WIDTH-1:0]   c_result_id_i,
  input  logic [NUM_COPROC*DATA_WIDTH-1:0] c_result_data_i,
  output logic                             x_result_valid_o,
  input  logic                             x_result_ready_i,
  output logic [ID_WIDTH-1:0]              x_result_id_o,
  output logic [DATA_WIDTH-1:0]            x_result_data_o,
  output logic                             multi_accept_err_o
);
  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam int OWN_W   = $clog2(NUM_COPROC);

  logic [NUM_IDS-1:0] ent_valid;
  logic [OWN_W-1:0]   ent_owner [NUM_IDS];
  logic [OWN_W-1:0]   rr_ptr;

  logic             issue_busy;
  logic             issue_hs;
  logic             multi_accept;
  logic [OWN_W-1:0] accept_idx;
  logic             commit_hit;
  logic             kill_clr;
  logic             res_clr;
  logic             grant_any;
  logic [OWN_W-1:0] grant_idx;
  logic             out_free;
  logic             res_hs;
  int               rr_idx;

  // An id still in flight blocks reissue until its entry has been cleared.
  assign issue_busy       = ent_valid[x_issue_id_i];
  assign x_issue_ready_o  = ~rst_i & ~issue_busy & (&c_issue_ready_i);
  assign c_issue_valid_o  = {NUM_COPROC{~rst_i & ~issue_busy & x_issue_valid_i}};
  assign c_issue_id_o     = x_issue_id_i;
  assign c_issue_instr_o  = x_issue_instr_i;
  assign x_issue_accept_o = |c_issue_accept_i;
  assign issue_hs         = x_issue_valid_i & x_issue_ready_o;
  assign multi_accept     = |(c_issue_accept_i & (c_issue_accept_i - NUM_COPROC'(1)));

  always_comb begin
    accept_idx = '0;
    for (int i = NUM_COPROC - 1; i >= 0; i--)
      if (c_issue_accept_i[i]) accept_idx = OWN_W'(i);
  end

  assign commit_hit      = ~rst_i & x_commit_valid_i & ent_valid[x_commit_id_i];
  assign c_commit_id_o   = x_commit_id_i;
  assign c_commit_kill_o = x_commit_kill_i;

  always_comb begin
    c_commit_valid_o = '0;
    for (int i = 0; i < NUM_COPROC; i++)
      c_commit_valid_o[i] = commit_hit & (ent_owner[x_commit_id_i] == OWN_W'(i));
  end

  assign kill_clr = x_commit_valid_i & x_commit_kill_i & ent_valid[x_commit_id_i];
  // Results for ids with no entry are forwarded but must not touch the table.
  assign res_clr  = x_result_valid_o & x_result_ready_i & ent_valid[x_result_id_o];

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_COPROC; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_COPROC) rr_idx = rr_idx - NUM_COPROC;
      if (!grant_any && c_result_valid_i[rr_idx]) begin
        grant_any = 1'b1;
        grant_idx = OWN_W'(rr_idx);
      end
    end
  end

  assign out_free = ~x_result_valid_o | x_result_ready_i;
  assign res_hs   = ~rst_i & grant_any & out_free;

  always_comb begin
    c_result_ready_o = '0;
    if (res_hs) c_result_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_valid          <= '0;
      rr_ptr             <= '0;
      x_result_valid_o   <= 1'b0;
      x_result_id_o      <= '0;
      x_result_data_o    <= '0;
      multi_accept_err_o <= 1'b0;
    end else begin
      multi_accept_err_o <= issue_hs & multi_accept;
      if (issue_hs & x_issue_accept_o) ent_valid[x_issue_id_i] <= 1'b1;
      if (kill_clr) ent_valid[x_commit_id_i] <= 1'b0;
      if (res_clr)  ent_valid[x_result_id_o] <= 1'b0;
      if (res_hs) begin
        x_result_valid_o <= 1'b1;
        x_result_id_o    <= c_result_id_i[grant_idx*ID_WIDTH +: ID_WIDTH];
        x_result_data_o  <= c_result_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr           <= (grant_idx == OWN_W'(NUM_COPROC - 1)) ? '0 : grant_idx + OWN_W'(1);
      end else if (x_result_ready_i) begin
        x_result_valid_o <= 1'b0;
      end
    end
  end

  // Owner is only meaningful while the matching valid bit is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (issue_hs & x_issue_accept_o) ent_owner[x_issue_id_i] <= accept_idx;
  end

endmodule

// File: tb/tb_xif_coproc_mux.sv
// Self-checking bench for xif_coproc_mux: directed scenarios plus a randomized run
// against an id-table / round-robin reference model.
module tb_xif_coproc_mux;
  localparam int NC = 2;
  localparam int IW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic             x_issue_valid_i, x_issue_ready_o, x_issue_accept_o;
  logic [IW-1:0]    x_issue_id_i;
  logic [31:0]      x_issue_instr_i;
  logic [NC-1:0]    c_issue_valid_o, c_issue_ready_i, c_issue_accept_i;
  logic [IW-1:0]    c_issue_id_o;
  logic [31:0]      c_issue_instr_o;
  logic             x_commit_valid_i, x_commit_kill_i, c_commit_kill_o;
  logic [IW-1:0]    x_commit_id_i, c_commit_id_o;
  logic [NC-1:0]    c_commit_valid_o;
  logic [NC-1:0]    c_result_valid_i, c_result_ready_o;
  logic [NC*IW-1:0] c_result_id_i;
  logic [NC*DW-1:0] c_result_data_i;
  logic             x_result_valid_o, x_result_ready_i, multi_accept_err_o;
  logic [IW-1:0]    x_result_id_o;
  logic [DW-1:0]    x_result_data_o;

  int n_pass  = 0;
  int n_total = 0;

  bit          m_valid [16];
  int          m_owner [16];
  int          m_rr;
  bit          m_ov;
  int          m_oid;
  logic [31:0] m_odata;
  bit          m_err;

  xif_coproc_mux #(.NUM_COPROC(NC), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
    .x_issue_id_i(x_issue_id_i), .x_issue_instr_i(x_issue_instr_i),
    .x_issue_accept_o(x_issue_accept_o),
    .c_issue_valid_o(c_issue_valid_o), .c_issue_ready_i(c_issue_ready_i),
    .c_issue_accept_i(c_issue_accept_i), .c_issue_id_o(c_issue_id_o),
    .c_issue_instr_o(c_issue_instr_o),
    .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
    .x_commit_kill_i(x_commit_kill_i), .c_commit_valid_o(c_commit_valid_o),
    .c_commit_id_o(c_commit_id_o), .c_commit_kill_o(c_commit_kill_o),
    .c_result_valid_i(c_result_valid_i), .c_result_ready_o(c_result_ready_o),
    .c_result_id_i(c_result_id_i), .c_result_data_i(c_result_data_i),
    .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
    .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
    .multi_accept_err_o(multi_accept_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    x_issue_valid_i  = 1'b0;
    x_issue_id_i     = '0;
    x_issue_instr_i  = '0;
    c_issue_ready_i  = 2'b11;
    c_issue_accept_i = 2'b00;
    x_commit_valid_i = 1'b0;
    x_commit_id_i    = '0;
    x_commit_kill_i  = 1'b0;
    c_result_valid_i = 2'b00;
    c_result_id_i    = '0;
    c_result_data_i  = '0;
    x_result_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    x_issue_valid_i  = 1'b1;
    x_commit_valid_i = 1'b1;
    c_result_valid_i = 2'b11;
    tick();
    tick();
    n_total++; if (x_issue_ready_o !== 1'b0) $display("FAIL rst_issue_ready got=%0h exp=0", x_issue_ready_o); else n_pass++;
    n_total++; if (c_issue_valid_o !== 2'b00) $display("FAIL rst_c_issue_valid got=%0h exp=0", c_issue_valid_o); else n_pass++;
    n_total++; if (c_commit_valid_o !== 2'b00) $display("FAIL rst_c_commit_valid got=%0h exp=0", c_commit_valid_o); else n_pass++;
    n_total++; if (c_result_ready_o !== 2'b00) $display("FAIL rst_c_result_ready got=%0h exp=0", c_result_ready_o); else n_pass++;
    n_total++; if (x_result_valid_o !== 1'b0) $display("FAIL rst_x_result_valid got=%0h exp=0", x_result_valid_o); else n_pass++;
    n_total++; if (x_result_id_o !== 4'd0 || x_result_data_o !== 32'd0) $display("FAIL rst_x_result_id_data got=%0h/%0h exp=0/0", x_result_id_o, x_result_data_o); else n_pass++;
    n_total++; if (multi_accept_err_o !== 1'b0) $display("FAIL rst_multi_err got=%0h exp=0", multi_accept_err_o); else n_pass++;
    rst_i = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_commit_route();
    x_issue_valid_i  = 1'b1;
    x_issue_id_i     = 4'd3;
    x_issue_instr_i  = 32'h1234_5678;
    c_issue_accept_i = 2'b10;
    #1;
    n_total++; if (x_issue_ready_o !== 1'b1) $display("FAIL route_issue_ready got=%0h exp=1", x_issue_ready_o); else n_pass++;
    n_total++; if (c_issue_valid_o !== 2'b11) $display("FAIL route_c_issue_valid got=%0h exp=3", c_issue_valid_o); else n_pass++;
    n_total++; if (c_issue_instr_o !== 32'h1234_5678 || c_issue_id_o !== 4'd3) $display("FAIL route_issue_pass got=%0h/%0h exp=12345678/3", c_issue_instr_o, c_issue_id_o); else n_pass++;
    n_total++; if (x_issue_accept_o !== 1'b1) $display("FAIL route_accept got=%0h exp=1", x_issue_accept_o); else n_pass++;
    tick();
    idle();
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = 4'd3;
    #1;
    n_total++; if (c_commit_valid_o !== 2'b10) $display("FAIL route_commit_valid got=%0h exp=2", c_commit_valid_o); else n_pass++;
    tick();
    idle();
    c_result_valid_i = 2'b10;
    c_result_id_i    = {4'd3, 4'd0};
    c_result_data_i  = {32'hCAFE_0003, 32'h0};
    #1;
    n_total++; if (c_result_ready_o !== 2'b10) $display("FAIL route_result_ready got=%0h exp=2", c_result_ready_o); else n_pass++;
    tick();
    c_result_valid_i = 2'b00;
    #1;
    n_total++; if (x_result_valid_o !== 1'b1 || x_result_id_o !== 4'd3) $display("FAIL route_result_out got=%0h/%0h exp=1/3", x_result_valid_o, x_result_id_o); else n_pass++;
    n_total++; if (x_result_data_o !== 32'hCAFE_0003) $display("FAIL route_result_data got=%0h exp=cafe0003", x_result_data_o); else n_pass++;
    tick();
    n_total++; if (x_result_valid_o !== 1'b0) $display("FAIL route_result_drain got=%0h exp=0", x_result_valid_o); else n_pass++;
    x_issue_valid_i = 1'b1;
    x_issue_id_i    = 4'd3;
    #1;
    n_total++; if (x_issue_ready_o !== 1'b1) $display("FAIL route_id_freed got=%0h exp=1", x_issue_ready_o); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_id_stall();
    x_issue_valid_i  = 1'b1;
    x_issue_id_i     = 4'd5;
    c_issue_accept_i = 2'b01;
    tick();
    c_issue_accept_i = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (x_issue_ready_o !== 1'b0 || c_issue_valid_o !== 2'b00) $display("FAIL stall_reissue got=%0h/%0h exp=0/0", x_issue_ready_o, c_issue_valid_o); else n_pass++;
      tick();
    end
    c_result_valid_i = 2'b01;
    c_result_id_i    = {4'd0, 4'd5};
    c_result_data_i  = {32'h0, 32'h0000_0555};
    #1;
    n_total++; if (c_result_ready_o !== 2'b01) $display("FAIL stall_result_ready got=%0h exp=1", c_result_ready_o); else n_pass++;
    tick();
    c_result_valid_i = 2'b00;
    #1;
    n_total++; if (x_result_valid_o !== 1'b1 || x_result_id_o !== 4'd5) $display("FAIL stall_result_out got=%0h/%0h exp=1/5", x_result_valid_o, x_result_id_o); else n_pass++;
    n_total++; if (x_issue_ready_o !== 1'b0) $display("FAIL stall_no_bypass got=%0h exp=0", x_issue_ready_o); else n_pass++;
    tick();
    n_total++; if (x_issue_ready_o !== 1'b1) $display("FAIL stall_release got=%0h exp=1", x_issue_ready_o); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_multi_accept();
    x_issue_valid_i  = 1'b1;
    x_issue_id_i     = 4'd2;
    c_issue_accept_i = 2'b11;
    #1;
    n_total++; if (multi_accept_err_o !== 1'b0) $display("FAIL multi_err_early got=%0h exp=0", multi_accept_err_o); else n_pass++;
    tick();
    idle();
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = 4'd2;
    #1;
    n_total++; if (multi_accept_err_o !== 1'b1) $display("FAIL multi_err_pulse got=%0h exp=1", multi_accept_err_o); else n_pass++;
    n_total++; if (c_commit_valid_o !== 2'b01) $display("FAIL multi_owner got=%0h exp=1", c_commit_valid_o); else n_pass++;
    tick();
    n_total++; if (multi_accept_err_o !== 1'b0) $display("FAIL multi_err_width got=%0h exp=0", multi_accept_err_o); else n_pass++;
    x_commit_kill_i = 1'b1;
    tick();
    x_commit_kill_i = 1'b0;
    #1;
    n_total++; if (c_commit_valid_o !== 2'b00) $display("FAIL kill_cleared got=%0h exp=0", c_commit_valid_o); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_rr_alternate();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    c_result_valid_i = 2'b11;
    c_result_id_i    = {4'd9, 4'd8};
    c_result_data_i  = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int k = 0; k < 6; k++) begin
      #1;
      n_total++; if (c_result_ready_o !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL rr_grant_%0d got=%0h", k, c_result_ready_o); else n_pass++;
      if (k > 0) begin
        n_total++; if (x_result_valid_o !== 1'b1 || x_result_id_o !== (((k - 1) % 2 == 0) ? 4'd8 : 4'd9)) $display("FAIL rr_out_%0d got=%0h/%0h", k, x_result_valid_o, x_result_id_o); else n_pass++;
      end
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    c_result_valid_i = 2'b01;
    c_result_id_i    = {4'd0, 4'd4};
    c_result_data_i  = {32'h0, 32'h4444_0004};
    x_result_ready_i = 1'b0;
    #1;
    n_total++; if (c_result_ready_o !== 2'b01) $display("FAIL bp_first_grant got=%0h exp=1", c_result_ready_o); else n_pass++;
    tick();
    c_result_valid_i = 2'b11;
    c_result_id_i    = {4'd6, 4'd1};
    c_result_data_i  = {32'h6666_0006, 32'h1111_0001};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (x_result_valid_o !== 1'b1 || x_result_id_o !== 4'd4 || x_result_data_o !== 32'h4444_0004) $display("FAIL bp_hold_%0d got=%0h/%0h/%0h exp=1/4/44440004", k, x_result_valid_o, x_result_id_o, x_result_data_o); else n_pass++;
      n_total++; if (c_result_ready_o !== 2'b00) $display("FAIL bp_ready_%0d got=%0h exp=0", k, c_result_ready_o); else n_pass++;
      tick();
    end
    x_result_ready_i = 1'b1;
    #1;
    n_total++; if (c_result_ready_o !== 2'b10) $display("FAIL bp_release_grant got=%0h exp=2", c_result_ready_o); else n_pass++;
    tick();
    c_result_valid_i = 2'b00;
    #1;
    n_total++; if (x_result_valid_o !== 1'b1 || x_result_id_o !== 4'd6 || x_result_data_o !== 32'h6666_0006) $display("FAIL bp_next_out got=%0h/%0h/%0h exp=1/6/66660006", x_result_valid_o, x_result_id_o, x_result_data_o); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_reset_midstream();
    x_issue_valid_i  = 1'b1;
    x_issue_id_i     = 4'd9;
    c_issue_accept_i = 2'b01;
    tick();
    x_issue_id_i     = 4'd7;
    c_issue_accept_i = 2'b10;
    tick();
    idle();
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = 4'd7;
    x_commit_kill_i  = 1'b1;
    c_result_valid_i = 2'b01;
    c_result_id_i    = {4'd0, 4'd1};
    #1;
    n_total++; if (c_commit_valid_o !== 2'b10) $display("FAIL mid_kill_route got=%0h exp=2", c_commit_valid_o); else n_pass++;
    tick();
    rst_i            = 1'b1;
    x_commit_valid_i = 1'b0;
    x_issue_valid_i  = 1'b1;
    x_issue_id_i     = 4'd0;
    c_result_valid_i = 2'b11;
    #1;
    n_total++; if (c_result_ready_o !== 2'b00 || x_issue_ready_o !== 1'b0 || c_issue_valid_o !== 2'b00) $display("FAIL mid_rst_gating got=%0h/%0h/%0h exp=0/0/0", c_result_ready_o, x_issue_ready_o, c_issue_valid_o); else n_pass++;
    tick();
    n_total++; if (x_result_valid_o !== 1'b0 || x_result_id_o !== 4'd0) $display("FAIL mid_rst_out got=%0h/%0h exp=0/0", x_result_valid_o, x_result_id_o); else n_pass++;
    tick();
    rst_i = 1'b0;
    idle();
    c_result_valid_i = 2'b11;
    x_result_ready_i = 1'b0;
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = 4'd9;
    #1;
    n_total++; if (c_result_ready_o !== 2'b01) $display("FAIL mid_rr_reset got=%0h exp=1", c_result_ready_o); else n_pass++;
    n_total++; if (c_commit_valid_o !== 2'b00) $display("FAIL mid_table_empty got=%0h exp=0", c_commit_valid_o); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    int          g;
    bit          found, free, hs, kill_clr, res_clr, exp_rdy;
    logic [1:0]  exp_rr, exp_cm, exp_civ;
    int          rid [NC];
    logic [31:0] rdat [NC];
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_rr = 0; m_ov = 1'b0; m_oid = 0; m_odata = '0; m_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      x_issue_valid_i  = ($urandom_range(0, 1) == 1);
      x_issue_id_i     = 4'($urandom_range(0, 15));
      x_issue_instr_i  = $urandom;
      c_issue_ready_i  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      c_issue_accept_i = 2'($urandom_range(0, 3));
      x_commit_valid_i = ($urandom_range(0, 1) == 1);
      x_commit_id_i    = 4'($urandom_range(0, 15));
      x_commit_kill_i  = ($urandom_range(0, 2) == 0);
      c_result_valid_i = 2'($urandom_range(0, 3));
      for (int c = 0; c < NC; c++) begin
        rid[c]  = $urandom_range(0, 15);
        rdat[c] = $urandom;
      end
      c_result_id_i    = {4'(rid[1]), 4'(rid[0])};
      c_result_data_i  = {rdat[1], rdat[0]};
      x_result_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !m_valid[x_issue_id_i] && (c_issue_ready_i == 2'b11);
      exp_civ = (x_issue_valid_i && !m_valid[x_issue_id_i]) ? 2'b11 : 2'b00;
      exp_cm  = (x_commit_valid_i && m_valid[x_commit_id_i]) ? 2'(1 << m_owner[x_commit_id_i]) : 2'b00;
      free    = !m_ov || x_result_ready_i;
      found   = 1'b0;
      g       = 0;
      for (int k = 0; k < NC; k++)
        if (!found && c_result_valid_i[(m_rr + k) % NC]) begin
          found = 1'b1;
          g     = (m_rr + k) % NC;
        end
      exp_rr = (found && free) ? 2'(1 << g) : 2'b00;
      n_total++; if (x_issue_ready_o !== exp_rdy) $display("FAIL rnd_issue_ready cyc=%0d got=%0h exp=%0h", cyc, x_issue_ready_o, exp_rdy); else n_pass++;
      n_total++; if (c_issue_valid_o !== exp_civ) $display("FAIL rnd_c_issue_valid cyc=%0d got=%0h exp=%0h", cyc, c_issue_valid_o, exp_civ); else n_pass++;
      n_total++; if (c_commit_valid_o !== exp_cm) $display("FAIL rnd_commit cyc=%0d got=%0h exp=%0h", cyc, c_commit_valid_o, exp_cm); else n_pass++;
      n_total++; if (c_result_ready_o !== exp_rr) $display("FAIL rnd_result_ready cyc=%0d got=%0h exp=%0h", cyc, c_result_ready_o, exp_rr); else n_pass++;
      n_total++; if (x_result_valid_o !== m_ov) $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", cyc, x_result_valid_o, m_ov); else n_pass++;
      if (m_ov) begin
        n_total++; if (x_result_id_o !== 4'(m_oid) || x_result_data_o !== m_odata) $display("FAIL rnd_out_payload cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, x_result_id_o, x_result_data_o, m_oid, m_odata); else n_pass++;
      end
      n_total++; if (multi_accept_err_o !== m_err) $display("FAIL rnd_multi_err cyc=%0d got=%0h exp=%0h", cyc, multi_accept_err_o, m_err); else n_pass++;
      hs       = x_issue_valid_i && exp_rdy;
      kill_clr = x_commit_valid_i && x_commit_kill_i && m_valid[x_commit_id_i];
      res_clr  = m_ov && x_result_ready_i && m_valid[m_oid];
      if (kill_clr) m_valid[x_commit_id_i] = 1'b0;
      if (res_clr) m_valid[m_oid] = 1'b0;
      if (hs && c_issue_accept_i != 2'b00) begin
        m_valid[x_issue_id_i] = 1'b1;
        m_owner[x_issue_id_i] = c_issue_accept_i[0] ? 0 : 1;
      end
      m_err = hs && (c_issue_accept_i == 2'b11);
      if (found && free) begin
        m_ov    = 1'b1;
        m_oid   = rid[g];
        m_odata = rdat[g];
        m_rr    = (g + 1) % NC;
      end else if (x_result_ready_i) begin
        m_ov = 1'b0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_commit_route();
    test_id_stall();
    test_multi_accept();
    test_rr_alternate();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
